// File: rtl/field_extract_pipe.sv
// Per-channel field extractor with a 2-entry valid/ready buffer on each channel.
// Optional FIELD_HOLD_EN: non-hit entries repeat the last extracted field instead of DEFAULT_VAL.
module field_extract_pipe #(
    parameter int NUM_CH     = 3,
    parameter int MSG_BITS   = 256,
    parameter int FIELD_BITS = 32,
    parameter int CTRL_W     = 4,
    parameter int Q_TYPE     = 1,
    parameter int T_TYPE     = 2,
    parameter int Q_LSB      = 64,
    parameter int T_LSB      = 96,
    parameter logic [FIELD_BITS-1:0] DEFAULT_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         message_en,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    input  logic [NUM_CH*MSG_BITS-1:0]   message_bus,
    input  logic [NUM_CH*CTRL_W-1:0]     ctrl_bus,
    output logic [NUM_CH-1:0]            out_valid,
    input  logic [NUM_CH-1:0]            out_ready,
    output logic [NUM_CH*FIELD_BITS-1:0] field_bus,
    output logic [NUM_CH-1:0]            out_hit
);

    if ((Q_LSB + FIELD_BITS > MSG_BITS) || (T_LSB + FIELD_BITS > MSG_BITS)) begin : g_bad_lsb
        $error("field_extract_pipe: field position exceeds MSG_BITS");
    end

    // Only two field windows of each message are consumed.
    logic unused_msg_bits;
    assign unused_msg_bits = ^message_bus;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [MSG_BITS-1:0]   msg;
        logic [CTRL_W-1:0]     ctrl;
        logic [FIELD_BITS-1:0] mem_field [2];
        logic [1:0]            mem_hit;
        logic                  wr_ptr, rd_ptr;
        logic [1:0]            count, count_next;
        logic                  ready_q;
        logic                  push, pop;
        logic                  hit;
        logic [FIELD_BITS-1:0] field, fill;

        assign msg  = message_bus[c*MSG_BITS +: MSG_BITS];
        assign ctrl = ctrl_bus[c*CTRL_W +: CTRL_W];
        assign push = in_valid[c] & ready_q;
        assign pop  = (count != 2'd0) & out_ready[c];

`ifdef FIELD_HOLD_EN
        logic [FIELD_BITS-1:0] hold_q;
        assign fill = hold_q;

        always_ff @(posedge clk) begin
            if (!rst_n || flush)
                hold_q <= DEFAULT_VAL;
            else if (push && hit)
                hold_q <= field;
        end
`else
        assign fill = DEFAULT_VAL;
`endif

        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        always_comb begin
            hit   = 1'b0;
            field = fill;
            if (message_en && ctrl == CTRL_W'(Q_TYPE)) begin
                hit   = 1'b1;
                field = msg[Q_LSB +: FIELD_BITS];
            end else if (message_en && ctrl == CTRL_W'(T_TYPE)) begin
                hit   = 1'b1;
                field = msg[T_LSB +: FIELD_BITS];
            end
        end

        always_comb begin
            count_next = count;
            case ({push, pop})
                2'b10:   count_next = count + 2'd1;
                2'b01:   count_next = count - 2'd1;
                default: count_next = count;
            endcase
        end

        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk) begin
            if (!rst_n || flush) begin
                wr_ptr  <= 1'b0;
                rd_ptr  <= 1'b0;
                count   <= 2'd0;
                ready_q <= 1'b1;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
                count   <= count_next;
                ready_q <= (count_next != 2'd2);
            end
        end

        // NOTE: buffer storage has no reset; the count qualifies every read of it.
        always_ff @(posedge clk) begin
            if (push) begin
                mem_field[wr_ptr] <= field;
                mem_hit[wr_ptr]   <= hit;
            end
        end

        assign in_ready[c]  = ready_q;
        assign out_valid[c] = (count != 2'd0);
        assign field_bus[c*FIELD_BITS +: FIELD_BITS] = out_valid[c] ? mem_field[rd_ptr] : DEFAULT_VAL;
        assign out_hit[c]   = out_valid[c] & mem_hit[rd_ptr];
    end

endmodule
